// File: rtl/countdown_timer_mmss_pkg.sv
`default_nettype none
// ============================================================================
// Module  : countdown_timer_mmss_pkg
// Purpose : Shared definitions for the MM:SS countdown timer. Holds the FSM
//           state encodings, the BCD digit limits, and a digit clamp helper.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package countdown_timer_mmss_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  // BCD digit limits: units digits run 0..9, seconds tens run 0..5
  localparam logic [3:0] BCD_UNITS_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

  // Saturate a preset digit to its legal maximum
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_dec_60_down.sv
`default_nettype none
// ============================================================================
// Module  : counter_dec_60_down
// Purpose : Two-digit BCD down counter (mirror of the dec-60 up counter).
//           Counts TENS_MAX9 .. 00; TENS_MAX=5 gives 59..00, TENS_MAX=9 gives
//           99..00. Priority: clear, then load, then decrement.
// Ports   : clk_i      - clock
//           rst_ni     - asynchronous active-low reset
//           clr_i      - synchronous clear to 00
//           load_i     - load tens_i/units_i (already clamped by caller)
//           tens_i     - preset tens digit
//           units_i    - preset units digit
//           dec_i      - decrement by one
//           tens_o     - tens digit (registered)
//           units_o    - units digit (registered)
//           borrow_o   - combinational, high while the count is 00
// Rev     : 1.0 - initial release
// ============================================================================
module counter_dec_60_down
  import countdown_timer_mmss_pkg::*;
#(
  parameter int unsigned TENS_MAX = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] units_i,
  input  logic       dec_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       borrow_o
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr_i) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (load_i) begin
      tens_d  = tens_i;
      units_d = units_i;
    end else if (dec_i) begin
      if (units_q == 4'd0) begin
        units_d = BCD_UNITS_MAX;
        // Wrap of the tens digit is the borrow taken by the next stage
        tens_d  = (tens_q == 4'd0) ? 4'(TENS_MAX) : tens_q - 4'd1;
      end else begin
        units_d = units_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens_o   = tens_q;
  assign units_o  = units_q;
  assign borrow_o = (tens_q == 4'd0) && (units_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/countdown_timer_mmss.sv
`default_nettype none
// ============================================================================
// Module  : countdown_timer_mmss
// Purpose : MM:SS BCD countdown timer with IDLE/RUN/PAUSE/ALARM control and
//           an alarm that lasts ALARM_SEC one-second ticks.
// Ports   : clk_i        - system clock
//           reset_n_i    - asynchronous active-low reset
//           clk_sec_i    - one-clk 1 s tick
//           load_i       - one-clk pulse, capture set_* digits
//           set_*_i      - BCD preset digits (clamped on load)
//           start_i      - one-clk pulse, begin/resume countdown
//           stop_i       - one-clk pulse, pause/clear/silence
//           min10_o..sec1_o - current BCD value (registered)
//           running_o    - high in RUN
//           alarm_o      - high in ALARM
// Rev     : 1.0 - initial release
// ============================================================================
module countdown_timer_mmss
  import countdown_timer_mmss_pkg::*;
#(
  parameter int unsigned ALARM_SEC = 5
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       clk_sec_i,
  input  logic       load_i,
  input  logic [3:0] set_min10_i,
  input  logic [3:0] set_min1_i,
  input  logic [3:0] set_sec10_i,
  input  logic [3:0] set_sec1_i,
  input  logic       start_i,
  input  logic       stop_i,
  output logic [3:0] min10_o,
  output logic [3:0] min1_o,
  output logic [3:0] sec10_o,
  output logic [3:0] sec1_o,
  output logic       running_o,
  output logic       alarm_o
);

  localparam int unsigned CNT_W = (ALARM_SEC < 2) ? 1 : $clog2(ALARM_SEC);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;

  logic load_en, clr_en, dec_en;
  logic sec_zero, min_zero, is_zero, is_one;

  // Decrement sequence (per clk_sec tick in RUN)
  always_comb begin
    state_d = state_q;
    acnt_d  = acnt_q;
    load_en = 1'b0;
    clr_en  = 1'b0;
    dec_en  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_PAUSE;
        end else if (clk_sec_i) begin
          dec_en = 1'b1;
          // The tick that lands on 00:00 enters ALARM together with the digits
          if (is_one) begin
            state_d = ST_ALARM;
            acnt_d  = '0;
          end
        end
      end
      ST_ALARM: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          acnt_d  = '0;
        end else if (clk_sec_i) begin
          if (acnt_q == CNT_W'(ALARM_SEC - 1)) begin
            state_d = ST_IDLE;
            acnt_d  = '0;
          end else begin
            acnt_d = acnt_q + CNT_W'(1);
          end
        end
      end
      default: begin  // ST_IDLE, ST_PAUSE
        if (stop_i) begin
          // stop in IDLE swallows any coincident load/start
          if (state_q == ST_PAUSE) begin
            state_d = ST_IDLE;
            clr_en  = 1'b1;
          end
        end else if (load_i) begin
          load_en = 1'b1;
        end else if (start_i && !is_zero) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      acnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
    end
  end

  counter_dec_60_down #(.TENS_MAX(5)) u_sec (
    .clk_i    (clk_i),
    .rst_ni   (reset_n_i),
    .clr_i    (clr_en),
    .load_i   (load_en),
    .tens_i   (bcd_clamp(set_sec10_i, BCD_TENS_MAX)),
    .units_i  (bcd_clamp(set_sec1_i, BCD_UNITS_MAX)),
    .dec_i    (dec_en),
    .tens_o   (sec10_o),
    .units_o  (sec1_o),
    .borrow_o (sec_zero)
  );

  // Minutes step only when seconds wrap from 00 to 59
  counter_dec_60_down #(.TENS_MAX(9)) u_min (
    .clk_i    (clk_i),
    .rst_ni   (reset_n_i),
    .clr_i    (clr_en),
    .load_i   (load_en),
    .tens_i   (bcd_clamp(set_min10_i, BCD_UNITS_MAX)),
    .units_i  (bcd_clamp(set_min1_i, BCD_UNITS_MAX)),
    .dec_i    (dec_en && sec_zero),
    .tens_o   (min10_o),
    .units_o  (min1_o),
    .borrow_o (min_zero)
  );

  assign is_zero   = sec_zero && min_zero;
  assign is_one    = min_zero && (sec10_o == 4'd0) && (sec1_o == 4'd1);
  assign running_o = (state_q == ST_RUN);
  assign alarm_o   = (state_q == ST_ALARM);

endmodule
`default_nettype wire
